// File: rtl/reg_file_bypass_sb.sv
// Register file with byte-enabled writes, write-first read bypass and a per-register
// pending scoreboard (reserve sets, write clears). Two registered read ports.
module reg_file_bypass_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    READ,
  input  logic [ADDR_WIDTH-1:0]   ADDR_R1,
  input  logic [ADDR_WIDTH-1:0]   ADDR_R2,
  output logic [DATA_WIDTH-1:0]   DATA_R1,
  output logic [DATA_WIDTH-1:0]   DATA_R2,
  output logic                    BUSY_R1,
  output logic                    BUSY_R2,
  output logic                    RVALID,
  input  logic                    WRITE,
  input  logic [ADDR_WIDTH-1:0]   ADDR_W,
  input  logic [DATA_WIDTH-1:0]   DATA_W,
  input  logic [DATA_WIDTH/8-1:0] BE_W,
  input  logic                    RSV,
  input  logic [ADDR_WIDTH-1:0]   ADDR_RSV
);

  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_pend;

  logic                  w_wr_en;
  logic                  w_rsv_en;
  logic [DATA_WIDTH-1:0] w_wr_word;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;
  logic                  w_bz1;
  logic                  w_bz2;

  // Register 0 is hardwired when ZERO_REG is set: writes and reserves to it are dropped.
  assign w_wr_en  = WRITE && !(ZERO_REG && (ADDR_W == '0));
  assign w_rsv_en = RSV   && !(ZERO_REG && (ADDR_RSV == '0));

  always_comb begin
    w_wr_word = r_mem[ADDR_W];
    for (int unsigned k = 0; k < NBYTES; k++) begin
      if (BE_W[k]) w_wr_word[8*k +: 8] = DATA_W[8*k +: 8];
    end
  end

  // Read port 1: write-first bypass; busy sees this cycle's write-clear but not its reserve.
  always_comb begin
    w_rd1 = r_mem[ADDR_R1];
    w_bz1 = r_pend[ADDR_R1];
    if (ZERO_REG && (ADDR_R1 == '0)) begin
      w_rd1 = '0;
      w_bz1 = 1'b0;
    end else if (w_wr_en && (ADDR_W == ADDR_R1)) begin
      w_rd1 = w_wr_word;
      w_bz1 = 1'b0;
    end
  end

  always_comb begin
    w_rd2 = r_mem[ADDR_R2];
    w_bz2 = r_pend[ADDR_R2];
    if (ZERO_REG && (ADDR_R2 == '0)) begin
      w_rd2 = '0;
      w_bz2 = 1'b0;
    end else if (w_wr_en && (ADDR_W == ADDR_R2)) begin
      w_rd2 = w_wr_word;
      w_bz2 = 1'b0;
    end
  end

  // Storage and scoreboard; the later reserve assignment wins over a same-address clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_pend <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[ADDR_W]  <= w_wr_word;
        r_pend[ADDR_W] <= 1'b0;
      end
      if (w_rsv_en) r_pend[ADDR_RSV] <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DATA_R1 <= '0;
      DATA_R2 <= '0;
      BUSY_R1 <= 1'b0;
      BUSY_R2 <= 1'b0;
      RVALID  <= 1'b0;
    end else begin
      RVALID <= READ;
      if (READ) begin
        DATA_R1 <= w_rd1;
        DATA_R2 <= w_rd2;
        BUSY_R1 <= w_bz1;
        BUSY_R2 <= w_bz2;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_bypass_sb.sv
// Bench for reg_file_bypass_sb: one instance with ZERO_REG=1 and one with ZERO_REG=0
// share the same stimulus and are compared against an array-based reference model.
module tb_reg_file_bypass_sb;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned BW    = DW / 8;
  localparam int unsigned DEPTH = 2 ** AW;

  logic          CLK = 1'b0;
  logic          RST;
  logic          READ;
  logic [AW-1:0] ADDR_R1, ADDR_R2, ADDR_W, ADDR_RSV;
  logic          WRITE, RSV;
  logic [DW-1:0] DATA_W;
  logic [BW-1:0] BE_W;

  logic [DW-1:0] z_d1, z_d2, n_d1, n_d2;
  logic          z_b1, z_b2, z_rv, n_b1, n_b2, n_rv;

  int total = 0;
  int bad   = 0;

  // Reference state per variant: index 0 = ZERO_REG=1, index 1 = ZERO_REG=0.
  logic [DW-1:0] m_mem  [2][DEPTH];
  logic          m_pend [2][DEPTH];
  logic [DW-1:0] e_d1 [2], e_d2 [2];
  logic          e_b1 [2], e_b2 [2], e_rv [2];

  always #5 CLK = ~CLK;

  reg_file_bypass_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1)) dut_z (
    .CLK(CLK), .RST(RST), .READ(READ), .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2),
    .DATA_R1(z_d1), .DATA_R2(z_d2), .BUSY_R1(z_b1), .BUSY_R2(z_b2), .RVALID(z_rv),
    .WRITE(WRITE), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
    .RSV(RSV), .ADDR_RSV(ADDR_RSV));

  reg_file_bypass_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b0)) dut_n (
    .CLK(CLK), .RST(RST), .READ(READ), .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2),
    .DATA_R1(n_d1), .DATA_R2(n_d2), .BUSY_R1(n_b1), .BUSY_R2(n_b2), .RVALID(n_rv),
    .WRITE(WRITE), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
    .RSV(RSV), .ADDR_RSV(ADDR_RSV));

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".z.rvalid"}, DW'(z_rv), DW'(e_rv[0]));
    chk({tag, ".z.d1"},     z_d1,      e_d1[0]);
    chk({tag, ".z.d2"},     z_d2,      e_d2[0]);
    chk({tag, ".z.b1"},     DW'(z_b1), DW'(e_b1[0]));
    chk({tag, ".z.b2"},     DW'(z_b2), DW'(e_b2[0]));
    chk({tag, ".n.rvalid"}, DW'(n_rv), DW'(e_rv[1]));
    chk({tag, ".n.d1"},     n_d1,      e_d1[1]);
    chk({tag, ".n.d2"},     n_d2,      e_d2[1]);
    chk({tag, ".n.b1"},     DW'(n_b1), DW'(e_b1[1]));
    chk({tag, ".n.b2"},     DW'(n_b2), DW'(e_b2[1]));
  endtask

  task automatic model_clear();
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        m_mem[v][i]  = '0;
        m_pend[v][i] = 1'b0;
      end
      e_d1[v] = '0; e_d2[v] = '0; e_b1[v] = 1'b0; e_b2[v] = 1'b0; e_rv[v] = 1'b0;
    end
  endtask

  // One clock edge of the architectural behaviour: apply write (data + clear),
  // sample reads from the post-write state, then apply the reserve.
  task automatic model_edge();
    bit zr;
    for (int v = 0; v < 2; v++) begin
      zr = (v == 0);
      if (WRITE && !(zr && ADDR_W == 0)) begin
        for (int k = 0; k < int'(BW); k++)
          if (BE_W[k]) m_mem[v][ADDR_W][8*k +: 8] = DATA_W[8*k +: 8];
        m_pend[v][ADDR_W] = 1'b0;
      end
      e_rv[v] = READ;
      if (READ) begin
        e_d1[v] = (zr && ADDR_R1 == 0) ? '0   : m_mem[v][ADDR_R1];
        e_d2[v] = (zr && ADDR_R2 == 0) ? '0   : m_mem[v][ADDR_R2];
        e_b1[v] = (zr && ADDR_R1 == 0) ? 1'b0 : m_pend[v][ADDR_R1];
        e_b2[v] = (zr && ADDR_R2 == 0) ? 1'b0 : m_pend[v][ADDR_R2];
      end
      if (RSV && !(zr && ADDR_RSV == 0)) m_pend[v][ADDR_RSV] = 1'b1;
    end
  endtask

  task automatic drv(input logic rd, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                     input logic wr, input logic [AW-1:0] aw, input logic [DW-1:0] dw,
                     input logic [BW-1:0] be, input logic rs, input logic [AW-1:0] ars);
    READ = rd; ADDR_R1 = a1; ADDR_R2 = a2;
    WRITE = wr; ADDR_W = aw; DATA_W = dw; BE_W = be;
    RSV = rs; ADDR_RSV = ars;
  endtask

  task automatic idle();
    drv(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic step(input string tag);
    if (!RST) model_edge();
    @(posedge CLK);
    #1;
    chk_all(tag);
  endtask

  // Reset asserted between edges must clear outputs without waiting for a clock.
  task automatic do_reset(input string tag);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    model_clear();
    chk_all({tag, ".async"});
    step({tag, ".held"});
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b0;
    idle();
    do_reset("por");

    // Reset scenario: reg5 written then read, reset discards it.
    drv(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0); step("w5");
    drv(1'b1, 5'd5, 5'd5, 1'b0, 5'd0, '0, '0, 1'b0, 5'd0);            step("r5");
    chk("r5.const", z_d1, 32'hDEADBEEF);
    drv(1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 32'h1, 4'hF, 1'b1, 5'd5);
    do_reset("midrst");
    chk("midrst.const.rv", DW'(z_rv), 32'h0);
    drv(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, '0, '0, 1'b0, 5'd0);            step("r5post");
    chk("r5post.const", z_d1, 32'h0);

    // Byte-enable merge.
    drv(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h11223344, 4'hF, 1'b0, 5'd0); step("w3");
    drv(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'hAABBCCDD, 4'b0101, 1'b0, 5'd0); step("w3be");
    drv(1'b1, 5'd3, 5'd3, 1'b0, 5'd0, '0, '0, 1'b0, 5'd0);            step("r3");
    chk("r3.const", n_d2, 32'h11BB33DD);

    // Write-first bypass on both ports.
    drv(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h12345678, 4'hF, 1'b0, 5'd0); step("byp7");
    chk("byp7.const", z_d2, 32'h12345678);

    // Scoreboard sequence on reg9.
    drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, '0, '0, 1'b1, 5'd9);            step("rsv9");
    drv(1'b1, 5'd9, 5'd9, 1'b0, 5'd0, '0, '0, 1'b0, 5'd0);            step("rd9busy");
    chk("rd9busy.const", DW'(z_b1), 32'h1);
    drv(1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 32'h99, 4'hF, 1'b0, 5'd0);      step("wr9clr");
    chk("wr9clr.const", DW'(z_b1), 32'h0);
    drv(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h9A, 4'hF, 1'b1, 5'd9);      step("rsvwr9");
    drv(1'b1, 5'd9, 5'd2, 1'b0, 5'd0, '0, '0, 1'b0, 5'd0);            step("rd9win");
    chk("rd9win.const", DW'(n_b1), 32'h1);
    drv(1'b1, 5'd9, 5'd9, 1'b1, 5'd9, '0, 4'h0, 1'b0, 5'd0);          step("be0clr");

    // Register 0: hardwired in dut_z, ordinary in dut_n.
    drv(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 5'd0); step("zr");
    chk("zr.z.const", z_d1, 32'h0);
    chk("zr.n.const", n_d1, 32'hFFFFFFFF);
    drv(1'b1, 5'd0, 5'd1, 1'b0, 5'd0, '0, '0, 1'b0, 5'd0);            step("zr.again");

    // Hold when READ drops.
    drv(1'b0, 5'd0, 5'd0, 1'b1, 5'd2, 32'h55, 4'hF, 1'b0, 5'd0);      step("w2");
    drv(1'b1, 5'd2, 5'd2, 1'b0, 5'd0, '0, '0, 1'b0, 5'd0);            step("r2");
    drv(1'b0, 5'd4, 5'd6, 1'b0, 5'd0, '0, '0, 1'b0, 5'd0);            step("hold");
    chk("hold.const", z_d1, 32'h55);

    // Random traffic over a narrow address window to force collisions.
    for (int n = 0; n < 300; n++) begin
      drv(1'($urandom), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
          1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom), BW'($urandom),
          1'($urandom), AW'($urandom_range(0, 7)));
      step("rnd");
      if (n == 150) begin
        drv(1'b1, 5'd1, 5'd2, 1'b0, '0, '0, '0, 1'b0, '0);
        do_reset("rndrst");
      end
    end

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
